seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Four-digit multiplexed seven-segment display driver for the Spartan-3 board. It sits directly downstream of the 4-bit up counter: the counter output drives the low nibble of `value`, and the block shows it as hexadecimal on the board's common-anode display. A refresh divider rotates through the four digits. The displayed value is snapshotted once per frame so a digit never tears, and a short blanking gap at the start of each digit slot suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 50000: clocks per digit slot (1 kHz per digit at 50 MHz). Must be ≥ 2.
- `BLANK_CYCLES`, default 500: clocks at the start of each slot with all anodes off. Must satisfy 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- `clock` input 1: the single clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-low reset. Sampled at the rising edge of `clock`.
- `value` input 16: four hex nibbles. Digit 0 is `[3:0]` (counter output); digit 3 is `[15:12]`.
- `dp_in` input 4: decimal point request per digit, active-high. Bit k belongs to digit k.
- `seg` output 7: segment cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal-point cathode, active-low.
- `an` output 4: digit anodes, active-low. Bit k selects digit k.

## Operation
- Internal state:
  - `div_cnt`, width clog2(REFRESH_DIV).
  - `digit`, 2 bits.
  - `snap_val` (16 bits) and `snap_dp` (4 bits).
- Divider: `div_cnt` increments each cycle. At REFRESH_DIV−1 it returns to 0 and `digit` advances 0→1→2→3→0 (mod 4).
- Snapshot: `snap_val`/`snap_dp` load `value`/`dp_in` in the cycle where `div_cnt`==REFRESH_DIV−1 and `digit`==3 (frame wrap). They hold at all other times, so a change in `value` mid-frame is not visible until the next frame.
- Output registers, computed each cycle from the current `div_cnt`, `digit` and snapshot:
  - Blank window (`div_cnt` < BLANK_CYCLES): `an`=4'b1111, `seg`=7'h7F, `dp`=1.
  - Otherwise: `an`=~(1<<digit), `seg`=decode(`snap_val` nibble `digit`), `dp`=~`snap_dp[digit]`.
- Decode (active-low hex), by nibble value:
  - 0→40, 1→79, 2→24, 3→30
  - 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03
  - C→46, d→21, E→06, F→0E
- Reset (`reset`==0 at a rising edge) sets: `div_cnt`=0, `digit`=0, `snap_val`=0, `snap_dp`=0, `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- Reset asserted mid-frame takes effect at that edge. It discards the slot and the snapshot; no partial state is kept.

## Timing
- Output latency: one clock. The outputs in cycle n+1 reflect the internal state in cycle n.
- First cycle after reset release: `div_cnt`=0 and `digit`=0, so the outputs stay blanked for BLANK_CYCLES+1 cycles. Digit 0 is then driven, showing the snapshot value 0 (seg=7'h40) until the first frame wrap.
- First real snapshot: taken 4·REFRESH_DIV−1 cycles after reset release. It appears on `seg` one blank window plus one clock after that.
- Frame period: exactly 4·REFRESH_DIV clocks. Each digit is lit for REFRESH_DIV−BLANK_CYCLES clocks.
- With BLANK_CYCLES=0 there is no gap: `an` switches directly from one digit to the next on the slot boundary.
- `value` changing in the same cycle as the snapshot: the new value is captured, since it is sampled at that edge.
- Exactly one anode bit is low at any time outside the blank window and reset.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digit k ∈ {3,2,1} shows `seg`=7'h7F (anode still driven) when snapshot nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - `dp` is unaffected.
- `LEADING_ZERO_BLANK_EN` undefined: all four digits are always decoded, so 0x0005 shows as "0005".

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset and blank window: hold `reset`=0 for 3 clocks, then release.
  - `an`=1111, `seg`=7F, `dp`=1 during reset and for the first 3 cycles after release.
  - Cycle 4: `an`=1110 and `seg`=40.
- Rotation: `value`=16'h4321, run 2 frames.
  - In frame 2, `an` steps 1110→1101→1011→0111 every 8 clocks.
  - `seg` shows 79, 24, 30, 19 in that order, with 2 blank cycles before each digit.
- Snapshot integrity: `value`=16'h00A5, then change it to 16'h00F0 while `digit`==1.
  - The rest of that frame still shows A and 0.
  - The next frame's digit 0 shows `seg`=40 and digit 1 shows 0E.
- Decimal point: `dp_in`=4'b0100 → `dp`=0 only while `an`=1011 (outside the blank window); `dp`=1 otherwise.
- Counter wrap: drive `value[3:0]` from the up counter, stepping once per frame, from F to 0.
  - Digit 0 shows 0E, then 40 in the next frame.
  - Digits 1–3 show 40, or 7F when `LEADING_ZERO_BLANK_EN` is defined.
- Mid-frame reset: pull `reset` low for 1 clock while `digit`==2 → the next cycle has `an`=1111 and `seg`=7F, and the sequence restarts at digit 0 with snapshot 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed common-anode hex display driver
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits 3..1).
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYCLES);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       digit;
    logic [15:0]      snap_val;
    logic [3:0]       snap_dp;

    logic       slot_end;
    logic       frame_end;
    logic       in_blank;
    logic [3:0] cur_nib;
    logic       lz_blank;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [3:0] an_next;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (digit == 2'd3);
    assign in_blank  = (div_cnt < BLANK_LIM);

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt <= '0;
            digit   <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame-wide snapshot so a digit never shows a half-updated value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snap_val <= 16'h0000;
            snap_dp  <= 4'b0000;
        end else if (frame_end) begin
            snap_val <= value;
            snap_dp  <= dp_in;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        case (digit)
            2'd0:    cur_nib = snap_val[3:0];
            2'd1:    cur_nib = snap_val[7:4];
            2'd2:    cur_nib = snap_val[11:8];
            default: cur_nib = snap_val[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (digit)
            2'd1:    lz_blank = (snap_val[15:4]  == 12'h000);
            2'd2:    lz_blank = (snap_val[15:8]  == 8'h00);
            2'd3:    lz_blank = (snap_val[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!in_blank) begin
            an_next  = ~(4'b0001 << digit);
            seg_next = lz_blank ? SEG_OFF : hex_to_seg(cur_nib);
            dp_next  = ~snap_dp[digit];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a cycle-count model
module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg7_scan_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .dp_in (dp_in),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [11:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: edges since reset release, snapshot of last completed frame.
    int unsigned m_i = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  m_snap_dp = 4'h0;

    task automatic model_edge();
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] sh;
        logic [3:0]  one;
        int dv, dg;
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        if (!reset) begin
            m_i = 0; m_snap = 16'h0; m_snap_dp = 4'h0;
        end else begin
            dv = m_i % RD;
            dg = (m_i / RD) % 4;
            if (dv >= BL) begin
                one   = 4'b0001;
                e_an  = ~(one << dg);
                sh    = m_snap >> (4 * dg);
                e_seg = seg_tab[sh[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
                if (dg > 0 && sh == 16'h0) e_seg = 7'h7F;
`endif
                e_dp = ~m_snap_dp[dg];
            end
            if (m_i % FRAME == FRAME - 1) begin
                m_snap    = value;
                m_snap_dp = dp_in;
            end
            m_i++;
        end
        exp_q.push_back({e_an, e_seg, e_dp});
    endtask

    task automatic tick(input logic r, input logic [15:0] v, input logic [3:0] d);
        @(negedge clock);
        reset = r; value = v; dp_in = d;
        model_edge();
    endtask

    task automatic run(input int n, input logic [15:0] v, input logic [3:0] d);
        for (int k = 0; k < n; k++) tick(1'b1, v, d);
    endtask

    // Tick until the next edge will see the given digit / divider position.
    task automatic run_to(input int dg, input int dv, input logic [15:0] v, input logic [3:0] d);
        int guard;
        guard = 0;
        do begin
            tick(1'b1, v, d);
            guard++;
        end while (!(((m_i / RD) % 4 == dg) && (m_i % RD == dv)) && guard < 2 * FRAME);
    endtask

    always @(posedge clock) begin
        logic [11:0] e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({an, seg, dp} !== e) begin
                fails++;
                $display("FAIL out cyc%0d an/seg/dp got %b/%h/%b exp %b/%h/%b",
                         cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    end

    initial begin
        logic [15:0] rv;
        logic [3:0]  rd;
        reset = 1'b0; value = 16'h0; dp_in = 4'h0;
        repeat (3) tick(1'b0, 16'h0, 4'h0);
        run(2 * FRAME + 8, 16'h4321, 4'h0);
        run_to(0, 0, 16'h00A5, 4'h0);
        run_to(1, 4, 16'h00A5, 4'h0);
        run_to(0, 0, 16'h00F0, 4'h0);
        run(FRAME, 16'h00F0, 4'h0);
        run(2 * FRAME, 16'h1234, 4'b0100);
        run_to(0, 0, 16'h000F, 4'h0);
        run_to(0, 0, 16'h000F, 4'h0);
        run_to(0, 0, 16'h0000, 4'h0);
        run(FRAME, 16'h0000, 4'h0);
        run_to(2, 3, 16'h9ABC, 4'hF);
        tick(1'b0, 16'h9ABC, 4'hF);
        run(FRAME + 8, 16'h9ABC, 4'hF);
        for (int it = 0; it < 60; it++) begin
            rv = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rv = rv >> (4 * $urandom_range(1, 3));
            rd = 4'($urandom);
            if ($urandom_range(0, 14) == 0) tick(1'b0, rv, rd);
            run($urandom_range(1, 40), rv, rd);
        end
        repeat (3) @(posedge clock);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left %0d exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
